// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types and AXI constants used by the bank writeback path.
// The AXI channel structs are sized for the default bank-to-L2 AXI configuration.
package rvh_l1d_pkg;

    localparam int unsigned L1dPaddrW = 56;
    localparam int unsigned L1dBeatW  = 256;
    localparam int unsigned L1dIdW    = 4;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [1:0] AxiRespOkay  = 2'b00;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_SEND,
        WB_WAIT_B
    } rvh_l1d_wb_fsm_e;

    typedef struct packed {
        logic [L1dIdW-1:0]    awid;
        logic [L1dPaddrW-1:0] awaddr;
        logic [7:0]           awlen;
        logic [2:0]           awsize;
        logic [1:0]           awburst;
    } cache_mem_if_aw_t;

    typedef struct packed {
        logic [L1dBeatW-1:0] wdata;
        logic                wlast;
    } cache_mem_if_w_t;

    typedef struct packed {
        logic [L1dIdW-1:0] bid;
        logic [1:0]        bresp;
    } cache_mem_if_b_t;

endpackage

// File: rtl/std_dffr.sv
// Common register: asynchronous active-low reset to zero, loads every cycle.
module std_dffr #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/std_dffre.sv
// Common register: asynchronous active-low reset to zero, loads when enabled.
module std_dffre #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/std_dffrve.sv
// Common register: asynchronous active-low reset to ResetVal, loads when enabled.
module std_dffrve #(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= ResetVal;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rvh_l1d_bank_wb_axi_seq.sv
// Per-bank writeback sequencer: one buffered dirty line -> AW + W burst -> matching B -> done.
// RVH_L1D_WB_AW_W_OVERLAP_EN lets W beats go out before/with AW; otherwise W waits for AW.
module rvh_l1d_bank_wb_axi_seq
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned BEAT_W    = 256,
    parameter int unsigned PADDR_W   = 56,
    parameter int unsigned ID_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PADDR_W-1:0]            req_paddr,
    input  logic [ID_W-1:0]               req_id,
    input  logic [BURST_LEN*BEAT_W-1:0]   req_data,
    output logic                          awvalid,
    input  logic                          awready,
    output cache_mem_if_aw_t              aw,
    output logic                          wvalid,
    input  logic                          wready,
    output cache_mem_if_w_t               w,
    input  logic                          bvalid,
    output logic                          bready,
    input  cache_mem_if_b_t               b,
    output logic                          done_valid,
    output logic                          done_err,
    output logic                          busy
);

    localparam int unsigned LineOff = $clog2(BURST_LEN * BEAT_W / 8);
    localparam int unsigned CntW    = $clog2(BURST_LEN) + 1;

    localparam logic [PADDR_W-1:0] LineMask = {PADDR_W{1'b1}} << LineOff;
    localparam logic [CntW-1:0]    CntLast  = CntW'(BURST_LEN - 1);
    localparam logic [CntW-1:0]    CntFull  = CntW'(BURST_LEN);
    localparam logic [7:0]         AwLen    = 8'(BURST_LEN - 1);
    localparam logic [2:0]         AwSize   = 3'($clog2(BEAT_W / 8));

    rvh_l1d_wb_fsm_e             state_d, state_q;
    logic [1:0]                  state_raw_q;
    logic                        aw_sent_d, aw_sent_q;
    logic [CntW-1:0]             beat_cnt_d, beat_cnt_q;
    logic [CntW-1:0]             beat_sel;
    logic [PADDR_W-1:0]          paddr_q;
    logic [ID_W-1:0]             id_q;
    logic [BURST_LEN*BEAT_W-1:0] data_q;
    logic                        req_hs, aw_hs, w_hs, b_hs;
    logic                        w_pending;

    assign state_q = rvh_l1d_wb_fsm_e'(state_raw_q);

    assign req_hs = req_valid & req_ready;
    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign b_hs   = bready;

    always_comb begin
        state_d    = state_q;
        aw_sent_d  = aw_sent_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            WB_IDLE: begin
                if (req_hs) begin
                    state_d    = WB_SEND;
                    aw_sent_d  = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            WB_SEND: begin
                if (aw_hs) begin
                    aw_sent_d = 1'b1;
                end
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
                // Covers AW and the wlast beat completing in the same cycle.
                if (aw_sent_d && (beat_cnt_d == CntFull)) begin
                    state_d = WB_WAIT_B;
                end
            end
            WB_WAIT_B: begin
                if (b_hs) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == WB_IDLE);
        busy      = (state_q != WB_IDLE);
        awvalid   = (state_q == WB_SEND) && !aw_sent_q;
        w_pending = (state_q == WB_SEND) && (beat_cnt_q != CntFull);
`ifdef RVH_L1D_WB_AW_W_OVERLAP_EN
        wvalid    = w_pending;
`else
        wvalid    = w_pending && aw_sent_q;
`endif
        bready    = (state_q == WB_WAIT_B) && bvalid && (b.bid == L1dIdW'(id_q));

        // Clamp keeps the select in range once every beat has gone out.
        beat_sel  = (beat_cnt_q == CntFull) ? CntLast : beat_cnt_q;

        aw.awid    = L1dIdW'(id_q);
        aw.awaddr  = L1dPaddrW'(paddr_q);
        aw.awlen   = AwLen;
        aw.awsize  = AwSize;
        aw.awburst = AxiBurstIncr;

        w.wdata = L1dBeatW'(data_q[int'(beat_sel) * BEAT_W +: BEAT_W]);
        w.wlast = (beat_cnt_q == CntLast);
    end

    std_dffrve #(
        .Width    (2),
        .ResetVal (2'(WB_IDLE))
    ) u_state_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (state_d != state_q),
        .d_i    (state_d),
        .q_o    (state_raw_q)
    );

    std_dffr #(.Width(1)) u_aw_sent_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (aw_sent_d),
        .q_o    (aw_sent_q)
    );

    std_dffr #(.Width(CntW)) u_beat_cnt_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (beat_cnt_d),
        .q_o    (beat_cnt_q)
    );

    std_dffre #(.Width(PADDR_W)) u_paddr_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (req_hs),
        .d_i    (req_paddr & LineMask),
        .q_o    (paddr_q)
    );

    std_dffre #(.Width(ID_W)) u_id_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (req_hs),
        .d_i    (req_id),
        .q_o    (id_q)
    );

    std_dffre #(.Width(BURST_LEN * BEAT_W)) u_data_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (req_hs),
        .d_i    (req_data),
        .q_o    (data_q)
    );

    std_dffr #(.Width(1)) u_done_valid_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (b_hs),
        .q_o    (done_valid)
    );

    std_dffr #(.Width(1)) u_done_err_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (b_hs && (b.bresp != AxiRespOkay)),
        .q_o    (done_err)
    );

endmodule

// File: tb/tb_rvh_l1d_bank_wb_axi_seq.sv
// Bench for rvh_l1d_bank_wb_axi_seq: transaction-level model checked every cycle plus
// directed literal expectations for the single-line, backpressure, ID, error and reset cases.
module tb_rvh_l1d_bank_wb_axi_seq;
    import rvh_l1d_pkg::*;

    localparam int unsigned BL = 2;
    localparam int unsigned BW = 256;
    localparam int unsigned PW = 56;
    localparam int unsigned IW = 4;
`ifdef RVH_L1D_WB_AW_W_OVERLAP_EN
    localparam bit Overlap = 1'b1;
`else
    localparam bit Overlap = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req_valid, req_ready;
    logic [PW-1:0]       req_paddr;
    logic [IW-1:0]       req_id;
    logic [BL*BW-1:0]    req_data;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    cache_mem_if_aw_t    aw;
    cache_mem_if_w_t     w;
    cache_mem_if_b_t     b;
    logic                done_valid, done_err, busy;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rvh_l1d_bank_wb_axi_seq #(
        .BURST_LEN (BL),
        .BEAT_W    (BW),
        .PADDR_W   (PW),
        .ID_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_paddr  (req_paddr),
        .req_id     (req_id),
        .req_data   (req_data),
        .awvalid    (awvalid),
        .awready    (awready),
        .aw         (aw),
        .wvalid     (wvalid),
        .wready     (wready),
        .w          (w),
        .bvalid     (bvalid),
        .bready     (bready),
        .b          (b),
        .done_valid (done_valid),
        .done_err   (done_err),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BL*BW-1:0] mkline(input logic [31:0] seed);
        logic [BL*BW-1:0] r;
        for (int i = 0; i < BL * BW / 32; i++) r[i*32 +: 32] = seed + 32'(i);
        return r;
    endfunction

    // Transaction-level model: one line in flight, counted AW/W progress, B match by ID.
    bit               m_active, m_aw_done, m_waitb, m_done, m_err;
    int               m_beats;
    logic [PW-1:0]    m_addr;
    logic [IW-1:0]    m_id;
    logic [BL*BW-1:0] m_data;
    bit               e_aw, e_w, e_b;

    always @(negedge clk) begin
        if (!rst) begin
            m_active = 0; m_aw_done = 0; m_waitb = 0; m_done = 0; m_err = 0; m_beats = 0;
        end else begin
            e_aw = m_active && !m_waitb && !m_aw_done;
            e_w  = m_active && !m_waitb && (m_beats < BL) && (Overlap || m_aw_done);
            e_b  = m_waitb && bvalid && (b.bid == m_id);
            check("m_req_ready", req_ready, !m_active);
            check("m_busy", busy, m_active);
            check("m_awvalid", awvalid, e_aw);
            check("m_wvalid", wvalid, e_w);
            check("m_bready", bready, e_b);
            check("m_done_valid", done_valid, m_done);
            check("m_done_err", done_err, m_done && m_err);
            if (e_aw) begin
                check("m_awaddr", aw.awaddr, m_addr);
                check("m_awid", aw.awid, m_id);
                check("m_awlen", aw.awlen, BL - 1);
                check("m_awsize", aw.awsize, 3'd5);  // 32-byte beats
                check("m_awburst", aw.awburst, 2'b01);
            end
            if (e_w) begin
                check("m_wdata", w.wdata, m_data[m_beats*BW +: BW]);
                check("m_wlast", w.wlast, m_beats == BL - 1);
            end
            m_done = 0;
            if (!m_active) begin
                if (req_valid) begin
                    m_active = 1; m_aw_done = 0; m_waitb = 0; m_beats = 0;
                    m_addr = req_paddr & ~56'h3F;  // 64-byte line
                    m_id = req_id;
                    m_data = req_data;
                end
            end else if (!m_waitb) begin
                if (e_aw && awready) m_aw_done = 1;
                if (e_w && wready) m_beats++;
                if (m_aw_done && m_beats == BL) m_waitb = 1;
            end else if (e_b) begin
                m_done = 1;
                m_err = (b.bresp != 2'b00);
                m_active = 0;
                m_waitb = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle (cycle 0); returns early in cycle 1.
    task automatic issue(input logic [PW-1:0] pa, input logic [IW-1:0] id,
                         input logic [BL*BW-1:0] d);
        tick();
        req_valid = 1'b1; req_paddr = pa; req_id = id; req_data = d;
        @(negedge clk);
        check("issue_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_line(input logic [IW-1:0] id, input logic [1:0] resp);
        bit got = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            bvalid = 1'b1; b.bid = id; b.bresp = resp;
            @(negedge clk);
            if (bready) begin
                got = 1;
                break;
            end
        end
        check("b_accept_in_budget", got, 1'b1);
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("fin_done_valid", done_valid, got);
        check("fin_done_err", done_err, got && (resp != 2'b00));
        check("fin_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errs++;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BL*BW-1:0] l1, l2, l3, l4, l5, l6;
        bit got;
        l1 = mkline(32'hA000_0000); l2 = mkline(32'hB100_0000); l3 = mkline(32'hC200_0000);
        l4 = mkline(32'hD300_0000); l5 = mkline(32'hE400_0000); l6 = mkline(32'hF500_0000);
        req_valid = 0; req_paddr = '0; req_id = '0; req_data = '0;
        awready = 1; wready = 1; bvalid = 0; b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_done_err", done_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_awaddr", aw.awaddr, 56'h0);
        check("rst_wdata", w.wdata, 256'h0);
        tick();
        rst = 1'b1;
        tick();

        // Single line, slaves always ready
        issue(56'h1234_5678, 4'd3, l1);
        @(negedge clk);
        check("t1_c1_awvalid", awvalid, 1'b1);
        check("t1_c1_awaddr", aw.awaddr, 56'h1234_5640);
        check("t1_c1_awlen", aw.awlen, 8'd1);
        check("t1_c1_wvalid", wvalid, Overlap);
        tick();
        @(negedge clk);
        check("t1_c2_awvalid", awvalid, 1'b0);
        check("t1_c2_wvalid", wvalid, 1'b1);
        check("t1_c2_wdata", w.wdata, Overlap ? l1[511:256] : l1[255:0]);
        check("t1_c2_wlast", w.wlast, Overlap);
        tick();
        tick();
        @(negedge clk);
        check("t1_c4_busy", busy, 1'b1);
        tick();
        bvalid = 1'b1; b.bid = 4'd3; b.bresp = 2'b00;
        @(negedge clk);
        check("t1_c5_bready", bready, 1'b1);
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("t1_c6_done_valid", done_valid, 1'b1);
        check("t1_c6_done_err", done_err, 1'b0);
        check("t1_c6_req_ready", req_ready, 1'b1);

        // AW backpressure for cycles 1..4
        awready = 1'b0;
        issue(56'h00AB_CDEF_0123_45, 4'd1, l2);
        repeat (3) tick();
        @(negedge clk);
        check("t2_c4_awvalid", awvalid, 1'b1);
        check("t2_c4_awaddr", aw.awaddr, 56'h00AB_CDEF_0123_40);
        check("t2_c4_wvalid", wvalid, 1'b0);
        check("t2_c4_busy", busy, 1'b1);
        check("t2_c4_bready", bready, 1'b0);
        tick();
        awready = 1'b1;
        finish_line(4'd1, 2'b00);

        // Wrong-ID B is held off, matching ID accepted
        issue(56'h77_0000_1000, 4'd3, l3);
        repeat (4) tick();
        bvalid = 1'b1; b.bid = 4'd5; b.bresp = 2'b00;
        @(negedge clk);
        check("t3_wrong_id_bready", bready, 1'b0);
        tick();
        @(negedge clk);
        check("t3_wrong_id_bready2", bready, 1'b0);
        check("t3_wrong_id_no_done", done_valid, 1'b0);
        finish_line(4'd3, 2'b00);

        // SLVERR response
        issue(56'h5A_5A5A_5A5A_5A7F, 4'd2, l4);
        finish_line(4'd2, 2'b10);
        tick();
        @(negedge clk);
        check("t4_after_busy", busy, 1'b0);
        check("t4_after_done", done_valid, 1'b0);

        // Reset after beat 0
        issue(56'h00_1111_2222_3333, 4'd4, l5);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wvalid && wready) begin
                got = 1;
                break;
            end
            tick();
        end
        check("t5_beat0_seen", got, 1'b1);
        tick();
        wready = 1'b0;
        check("t5_mid_busy", busy, 1'b1);
        check("t5_mid_wvalid", wvalid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_awvalid", awvalid, 1'b0);
        check("t5_rst_wvalid", wvalid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_req_ready", req_ready, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        wready = 1'b1;
        issue(56'h00_4444_5555_6666, 4'd6, l6);
        @(negedge clk);
        check("t5_new_awvalid", awvalid, 1'b1);
        check("t5_new_awaddr", aw.awaddr, 56'h00_4444_5555_6640);
        got = 0;
        for (int i = 0; i < 4; i++) begin
            if (wvalid) begin
                got = 1;
                break;
            end
            tick();
            @(negedge clk);
        end
        check("t5_new_wvalid_seen", got, 1'b1);
        check("t5_new_beat0", w.wdata, l6[255:0]);
        finish_line(4'd6, 2'b00);

        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
